// File: rtl/delay_pkg.sv
// Shared limits and the parameter-legality check for the delay line.
package delay_pkg;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int DELAY_MIN = 0;
    localparam int DELAY_MAX = 64;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // True when the requested depth and width fall inside the supported envelope.
    function automatic bit delay_params_ok(input int delay_cycles, input int width_bits);
        return (delay_cycles >= DELAY_MIN) && (delay_cycles <= DELAY_MAX) &&
               (width_bits   >= WIDTH_MIN) && (width_bits   <= WIDTH_MAX);
    endfunction
endpackage

// File: rtl/delay_if.sv
// Point-to-point data link: one side drives a WIDTH-bit word, the other consumes it.
interface delay_if #(
    parameter int WIDTH = 1
) ();
    timeunit 1ns;
    timeprecision 100ps;

    logic [WIDTH-1:0] data;

    modport master (output data);
    modport slave  (input  data);
endinterface

// File: rtl/delay_stage.sv
// One pipeline register of the delay line, asynchronously cleared to RESET_VALUE.
module delay_stage #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    timeunit 1ns;
    timeprecision 100ps;

    logic [WIDTH-1:0] r_q;

    // Capture the input every rising edge; reset wins immediately and holds the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/delay.sv
// Fixed-latency delay line: d_out is d_in delayed by DELAY clock edges.
// DELAY = 0 collapses to a wire; otherwise d_out comes straight from the last register.
module delay
    import delay_pkg::*;
#(
    parameter int               DELAY       = 1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    input  logic             rst
);
    timeunit 1ns;
    timeprecision 100ps;

    // Refuse to elaborate outside the supported depth/width envelope.
    if (!delay_params_ok(DELAY, WIDTH)) begin : g_param_error
        $error("delay: DELAY must be 0..64 and WIDTH 1..64 (DELAY=%0d WIDTH=%0d)", DELAY, WIDTH);
    end

    if (DELAY == 0) begin : g_passthrough
        // Zero depth: no state, so clk and rst are intentionally left without effect.
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign d_out    = d_in;
    end else begin : g_pipeline
        // w_chain[0] is the input; w_chain[gi+1] is the output of stage gi.
        logic [WIDTH-1:0] w_chain [0:DELAY];

        assign w_chain[0] = d_in;

        for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
            delay_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .i_d (w_chain[gi]),
                .o_q (w_chain[gi+1])
            );
        end

        assign d_out = w_chain[DELAY];
    end
endmodule

// File: tb/tb_delay.sv
// Directed bench for the delay line across several parameter sets.
module tb_delay;
    timeunit 1ns;
    timeprecision 100ps;

    logic clk = 1'b0;
    always #1 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default parameters (DELAY=1, WIDTH=1, RESET_VALUE=0)
    logic       rst0, d0, q0;
    // DELAY=4, WIDTH=8, RESET_VALUE=A5, input driven through the link interface
    logic       rst4;
    logic [7:0] q4;
    delay_if #(.WIDTH(8)) u_if4 ();
    // DELAY=3, WIDTH=8, RESET_VALUE=0
    logic       rst3;
    logic [7:0] d3, q3;
    // DELAY=2, WIDTH=1, RESET_VALUE=1
    logic       rstr, dr, qr;
    // DELAY=0, WIDTH=8
    logic       rstz;
    logic [7:0] dz, qz;

    delay u_d0 (.clk(clk), .d_in(d0), .d_out(q0), .rst(rst0));

    delay #(.DELAY(4), .WIDTH(8), .RESET_VALUE(8'hA5)) u_d4 (
        .clk(clk), .d_in(u_if4.data), .d_out(q4), .rst(rst4));

    delay #(.DELAY(3), .WIDTH(8), .RESET_VALUE(8'h00)) u_d3 (
        .clk(clk), .d_in(d3), .d_out(q3), .rst(rst3));

    delay #(.DELAY(2), .WIDTH(1), .RESET_VALUE(1'b1)) u_dr (
        .clk(clk), .d_in(dr), .d_out(qr), .rst(rstr));

    delay #(.DELAY(0), .WIDTH(8)) u_dz (
        .clk(clk), .d_in(dz), .d_out(qz), .rst(rstz));

    // Pattern, then a single-cycle pulse (index 14) and a two-cycle pulse (17..18)
    logic in0  [21] = '{1,1,0,1,0,1,0,1,1,0,0,1,0,0,1,0,0,1,1,0,0};
    logic exp0 [21] = '{0,1,1,0,1,0,1,0,1,1,0,0,1,0,0,1,0,0,1,1,0};

    logic [7:0] exp4 [20] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5,
                              8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset everything at time 0; outputs must be at RESET_VALUE before any clock edge
        rst0 = 1'b1; rst4 = 1'b1; rst3 = 1'b1; rstr = 1'b1; rstz = 1'b1;
        d0 = 1'b1; u_if4.data = 8'h77; d3 = 8'h99; dr = 1'b0; dz = 8'h5A;
        #0.5;
        chk("rst_async_d1", 64'(q0), 64'h0);
        chk("rst_async_d4", 64'(q4), 64'hA5);
        chk("rst_async_d3", 64'(q3), 64'h00);
        chk("rst_async_rv1", 64'(qr), 64'h1);
        chk("d0_ignores_rst", 64'(qz), 64'h5A);

        // Release after a clock edge that occurred with reset held
        @(negedge clk);
        rst0 = 1'b0; rst4 = 1'b0; rst3 = 1'b0; rstr = 1'b0; rstz = 1'b0;
        d0 = 1'b0; u_if4.data = 8'h00; d3 = 8'h00;
        #0.2;
        chk("rst_edge_d1", 64'(q0), 64'h0);
        chk("rst_edge_d4", 64'(q4), 64'hA5);

        // Default instance: pattern and pulses appear exactly one edge later
        for (int s = 0; s < 21; s++) begin
            @(negedge clk);
            d0 = in0[s];
            #0.2;
            chk($sformatf("d1_step%0d", s), 64'(q0), 64'(exp0[s]));
        end

        // DELAY=4: fresh reset, then count 0x00..0x0F
        @(negedge clk);
        rst4 = 1'b1;
        #0.2;
        chk("d4_rst_flush", 64'(q4), 64'hA5);
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (s == 0) rst4 = 1'b0;
            u_if4.data = (s < 16) ? 8'(s) : 8'h00;
            #0.2;
            chk($sformatf("d4_step%0d", s), 64'(q4), 64'(exp4[s]));
            if (s == 9) begin
                // Glitch between edges must not be captured
                u_if4.data = 8'hFF;
                #0.3;
                u_if4.data = 8'h09;
            end
        end

        // DELAY=3: reset asserted with 0x22/0x33/0x44 in flight
        @(negedge clk); d3 = 8'h11; #0.2; chk("d3_s0", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h22; #0.2; chk("d3_s1", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h33; #0.2; chk("d3_s2", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h44; #0.2; chk("d3_s3", 64'(q3), 64'h11);
        @(negedge clk); d3 = 8'h55; #0.2; chk("d3_s4", 64'(q3), 64'h22);
        #0.2; rst3 = 1'b1;
        #0.2; chk("d3_rst_now", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h66; #0.2; chk("d3_rst_edge", 64'(q3), 64'h00);
        @(negedge clk); rst3 = 1'b0; d3 = 8'h77; #0.2; chk("d3_rel0", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h88; #0.2; chk("d3_rel1", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'h99; #0.2; chk("d3_rel2", 64'(q3), 64'h00);
        @(negedge clk); d3 = 8'hAA; #0.2; chk("d3_rel3", 64'(q3), 64'h77);
        @(negedge clk); d3 = 8'hBB; #0.2; chk("d3_rel4", 64'(q3), 64'h88);

        // RESET_VALUE=1, DELAY=2, input held at 0 through release
        @(negedge clk); rstr = 1'b1; #0.2; chk("rv1_rst", 64'(qr), 64'h1);
        @(negedge clk); rstr = 1'b0; #0.2; chk("rv1_e0", 64'(qr), 64'h1);
        @(negedge clk); #0.2; chk("rv1_e1", 64'(qr), 64'h1);
        @(negedge clk); #0.2; chk("rv1_e2", 64'(qr), 64'h0);
        @(negedge clk); #0.2; chk("rv1_e3", 64'(qr), 64'h0);

        // DELAY=0: combinational, unaffected by reset or clock
        @(negedge clk);
        dz = 8'h3C; #0.2; chk("d0_pass_a", 64'(qz), 64'h3C);
        rstz = 1'b1; #0.2; chk("d0_rst_hi", 64'(qz), 64'h3C);
        dz = 8'hC3; #0.2; chk("d0_pass_b", 64'(qz), 64'hC3);
        @(posedge clk); dz = 8'h81; #0.1; chk("d0_at_edge", 64'(qz), 64'h81);
        rstz = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
